aq_lsu_amo_wb: RTL and testbench

AQ_LSU_AMO_WB -- requirements
Module: aq_lsu_amo_wb

---
 rtl/aq_lsu_amo_wb.sv | 151 +++++++++++++++
 tb/tb_aq_lsu_amo_wb.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aq_lsu_amo_wb.sv
// AMO result write-back buffer: formats ALU results into store-buffer entries
// and holds them in a 2-entry FIFO until the store buffer grants the head.
module aq_lsu_amo_wb #(
    parameter logic [1:0] WORD  = 2'b10,
    parameter logic [1:0] DWORD = 2'b11
) (
    input  logic        amo_clk,
    input  logic        cpurst_b,
    input  logic        da_amo_src_vld,
    input  logic [1:0]  da_amo_alu_size,
    input  logic        da_amo_addr2,
    input  logic        amo_alu_stb_rst_vld,
    input  logic [1:0]  amo_alu_stb_id,
    input  logic [63:0] amo_alu_stb_rst,
    input  logic        stb_amo_wb_grant,
    input  logic        lsu_amo_wb_flush,
    output logic        amo_wb_stb_vld,
    output logic [1:0]  amo_wb_stb_id,
    output logic [63:0] amo_wb_stb_data,
    output logic [7:0]  amo_wb_stb_bytes_vld,
    output logic        amo_wb_full,
    output logic        amo_wb_busy,
    output logic        amo_wb_ovf
);

    localparam int unsigned DATA_W  = 64;
    localparam int unsigned HALF_W  = 32;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned ID_W    = 2;
    localparam int unsigned SIZE_W  = 2;
    localparam int unsigned CNT_W   = 2;
    localparam int unsigned DEPTH   = 2;

    localparam logic [CNT_W-1:0] CNT_EMPTY = 2'd0;
    localparam logic [CNT_W-1:0] CNT_ONE   = 2'd1;
    localparam logic [CNT_W-1:0] CNT_FULL  = 2'd2;

    logic [SIZE_W-1:0] r_attr_size;
    logic              r_attr_addr2;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_wptr;
    logic              r_rptr;
    logic              r_ovf;
    logic [ID_W-1:0]   r_id    [DEPTH];
    logic [DATA_W-1:0] r_data  [DEPTH];
    logic [BYTE_W-1:0] r_bytes [DEPTH];

    logic [DATA_W-1:0] w_push_data;
    logic [BYTE_W-1:0] w_push_bytes;
    logic              w_pop;
    logic              w_push_ok;
    logic              w_drop;
    logic [CNT_W-1:0]  w_cnt_nxt;

    // Issue-time attributes, consumed by the result push one cycle later
    always_ff @(posedge amo_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_attr_size  <= '0;
            r_attr_addr2 <= 1'b0;
        end else if (da_amo_src_vld) begin
            r_attr_size  <= da_amo_alu_size;
            r_attr_addr2 <= da_amo_addr2;
        end
    end

    // Lane formatting: a word result is replicated into both halves
    always_comb begin
        w_push_data  = amo_alu_stb_rst;
        w_push_bytes = 8'hFF;
        case (r_attr_size)
            WORD: begin
                w_push_data  = {amo_alu_stb_rst[HALF_W-1:0], amo_alu_stb_rst[HALF_W-1:0]};
                w_push_bytes = r_attr_addr2 ? 8'hF0 : 8'h0F;
            end
            DWORD: begin
                w_push_data  = amo_alu_stb_rst;
                w_push_bytes = 8'hFF;
            end
            default: begin
                w_push_data  = amo_alu_stb_rst;
                w_push_bytes = 8'hFF;
            end
        endcase
    end

    assign w_pop     = (r_cnt != CNT_EMPTY) & stb_amo_wb_grant;
    assign w_push_ok = amo_alu_stb_rst_vld & ((r_cnt != CNT_FULL) | w_pop);
    assign w_drop    = amo_alu_stb_rst_vld & (r_cnt == CNT_FULL) & ~w_pop & ~lsu_amo_wb_flush;

    always_comb begin
        w_cnt_nxt = r_cnt;
        case ({w_push_ok, w_pop})
            2'b10:   w_cnt_nxt = r_cnt + CNT_ONE;
            2'b01:   w_cnt_nxt = r_cnt - CNT_ONE;
            default: w_cnt_nxt = r_cnt;
        endcase
    end

    // When full with a pop, wptr already points at the slot being freed
    always_ff @(posedge amo_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_id[i]    <= '0;
                r_data[i]  <= '0;
                r_bytes[i] <= '0;
            end
        end else if (w_push_ok && !lsu_amo_wb_flush) begin
            r_id[r_wptr]    <= amo_alu_stb_id;
            r_data[r_wptr]  <= w_push_data;
            r_bytes[r_wptr] <= w_push_bytes;
        end
    end

    always_ff @(posedge amo_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_cnt  <= CNT_EMPTY;
            r_wptr <= 1'b0;
            r_rptr <= 1'b0;
        end else if (lsu_amo_wb_flush) begin
            r_cnt  <= CNT_EMPTY;
            r_wptr <= 1'b0;
            r_rptr <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            if (w_push_ok) begin
                r_wptr <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
        end
    end

    // Overflow is sticky until reset; flush leaves it alone
    always_ff @(posedge amo_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end
    end

    assign amo_wb_stb_vld       = (r_cnt != CNT_EMPTY);
    assign amo_wb_stb_id        = r_id[r_rptr];
    assign amo_wb_stb_data      = r_data[r_rptr];
    assign amo_wb_stb_bytes_vld = r_bytes[r_rptr];
    assign amo_wb_full          = (r_cnt == CNT_FULL);
    assign amo_wb_busy          = (r_cnt != CNT_EMPTY);
    assign amo_wb_ovf           = r_ovf;

endmodule

// File: tb/tb_aq_lsu_amo_wb.sv
// Bench for aq_lsu_amo_wb: directed scenarios plus random traffic, all
// checked every cycle against a queue-based model of the write-back buffer.
module tb_aq_lsu_amo_wb;

    logic        amo_clk;
    logic        cpurst_b;
    logic        da_amo_src_vld;
    logic [1:0]  da_amo_alu_size;
    logic        da_amo_addr2;
    logic        amo_alu_stb_rst_vld;
    logic [1:0]  amo_alu_stb_id;
    logic [63:0] amo_alu_stb_rst;
    logic        stb_amo_wb_grant;
    logic        lsu_amo_wb_flush;
    logic        amo_wb_stb_vld;
    logic [1:0]  amo_wb_stb_id;
    logic [63:0] amo_wb_stb_data;
    logic [7:0]  amo_wb_stb_bytes_vld;
    logic        amo_wb_full;
    logic        amo_wb_busy;
    logic        amo_wb_ovf;

    aq_lsu_amo_wb dut (
        .amo_clk              (amo_clk),
        .cpurst_b             (cpurst_b),
        .da_amo_src_vld       (da_amo_src_vld),
        .da_amo_alu_size      (da_amo_alu_size),
        .da_amo_addr2         (da_amo_addr2),
        .amo_alu_stb_rst_vld  (amo_alu_stb_rst_vld),
        .amo_alu_stb_id       (amo_alu_stb_id),
        .amo_alu_stb_rst      (amo_alu_stb_rst),
        .stb_amo_wb_grant     (stb_amo_wb_grant),
        .lsu_amo_wb_flush     (lsu_amo_wb_flush),
        .amo_wb_stb_vld       (amo_wb_stb_vld),
        .amo_wb_stb_id        (amo_wb_stb_id),
        .amo_wb_stb_data      (amo_wb_stb_data),
        .amo_wb_stb_bytes_vld (amo_wb_stb_bytes_vld),
        .amo_wb_full          (amo_wb_full),
        .amo_wb_busy          (amo_wb_busy),
        .amo_wb_ovf           (amo_wb_ovf)
    );

    initial amo_clk = 1'b0;
    always #5 amo_clk = ~amo_clk;

    typedef struct {
        logic [1:0]  id;
        logic [63:0] data;
        logic [7:0]  bytes;
    } entry_t;

    entry_t      m_q[$];
    logic [1:0]  m_size;
    logic        m_addr2;
    logic        m_ovf;
    int          n_chk;
    int          n_fail;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic entry_t fmt(input logic [1:0] id, input logic [63:0] rst,
                                   input logic [1:0] sz, input logic a2);
        entry_t e;
        e.id = id;
        if (sz == 2'b10) begin
            e.data  = {rst[31:0], rst[31:0]};
            e.bytes = a2 ? 8'hF0 : 8'h0F;
        end else begin
            e.data  = rst;
            e.bytes = 8'hFF;
        end
        return e;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_size  = 2'b00;
        m_addr2 = 1'b0;
        m_ovf   = 1'b0;
    endtask

    // Advance the model by one clock using the inputs currently driven
    task automatic model_step();
        bit pop;
        int n;
        n   = m_q.size();
        pop = (n != 0) && stb_amo_wb_grant;
        if (lsu_amo_wb_flush) begin
            m_q.delete();
        end else begin
            if (pop) void'(m_q.pop_front());
            if (amo_alu_stb_rst_vld) begin
                if (n == 2 && !pop) m_ovf = 1'b1;
                else m_q.push_back(fmt(amo_alu_stb_id, amo_alu_stb_rst, m_size, m_addr2));
            end
        end
        if (da_amo_src_vld) begin
            m_size  = da_amo_alu_size;
            m_addr2 = da_amo_addr2;
        end
    endtask

    task automatic compare_model();
        int n;
        n = m_q.size();
        chk("vld",  64'(amo_wb_stb_vld), 64'(n != 0));
        chk("full", 64'(amo_wb_full),    64'(n == 2));
        chk("busy", 64'(amo_wb_busy),    64'(n != 0));
        chk("ovf",  64'(amo_wb_ovf),     64'(m_ovf));
        if (n != 0) begin
            chk("head_id",    64'(amo_wb_stb_id),        64'(m_q[0].id));
            chk("head_data",  amo_wb_stb_data,            m_q[0].data);
            chk("head_bytes", 64'(amo_wb_stb_bytes_vld), 64'(m_q[0].bytes));
        end
    endtask

    // Drive one cycle at the negedge, clock it, then check at the next negedge
    task automatic cyc(input logic sv, input logic [1:0] sz, input logic a2,
                       input logic rv, input logic [1:0] id, input logic [63:0] rst,
                       input logic g, input logic fl);
        da_amo_src_vld      = sv;
        da_amo_alu_size     = sz;
        da_amo_addr2        = a2;
        amo_alu_stb_rst_vld = rv;
        amo_alu_stb_id      = id;
        amo_alu_stb_rst     = rst;
        stb_amo_wb_grant    = g;
        lsu_amo_wb_flush    = fl;
        model_step();
        @(posedge amo_clk);
        @(negedge amo_clk);
        compare_model();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_vld"},   64'(amo_wb_stb_vld),       64'd0);
        chk({tag, "_full"},  64'(amo_wb_full),          64'd0);
        chk({tag, "_busy"},  64'(amo_wb_busy),          64'd0);
        chk({tag, "_ovf"},   64'(amo_wb_ovf),           64'd0);
        chk({tag, "_id"},    64'(amo_wb_stb_id),        64'd0);
        chk({tag, "_data"},  amo_wb_stb_data,           64'd0);
        chk({tag, "_bytes"}, 64'(amo_wb_stb_bytes_vld), 64'd0);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        cpurst_b = 1'b0;
        da_amo_src_vld = 0; da_amo_alu_size = 0; da_amo_addr2 = 0;
        amo_alu_stb_rst_vld = 0; amo_alu_stb_id = 0; amo_alu_stb_rst = 0;
        stb_amo_wb_grant = 0; lsu_amo_wb_flush = 0;
        model_reset();
        repeat (3) @(negedge amo_clk);
        chk_all_zero("reset");
        cpurst_b = 1'b1;
        cyc(0, 2'b00, 0, 0, 2'd0, 64'd0, 0, 0);
        chk_all_zero("post_reset");

        // WORD upper lane
        cyc(1, 2'b10, 1, 0, 2'd0, 64'd0, 0, 0);
        cyc(0, 2'b00, 0, 1, 2'd2, 64'h1234_5678_9ABC_DEF0, 0, 0);
        chk("word_vld",   64'(amo_wb_stb_vld), 64'd1);
        chk("word_data",  amo_wb_stb_data, 64'h9ABC_DEF0_9ABC_DEF0);
        chk("word_bytes", 64'(amo_wb_stb_bytes_vld), 64'hF0);
        chk("word_id",    64'(amo_wb_stb_id), 64'd2);
        cyc(0, 2'b00, 0, 0, 2'd0, 64'd0, 1, 0);

        // DWORD with immediate grant
        cyc(1, 2'b11, 0, 0, 2'd0, 64'd0, 0, 0);
        cyc(0, 2'b00, 0, 1, 2'd1, 64'hFFFF_0000_1111_2222, 0, 0);
        chk("dword_data",  amo_wb_stb_data, 64'hFFFF_0000_1111_2222);
        chk("dword_bytes", 64'(amo_wb_stb_bytes_vld), 64'hFF);
        cyc(0, 2'b00, 0, 0, 2'd0, 64'd0, 1, 0);
        chk("dword_popped_vld", 64'(amo_wb_stb_vld), 64'd0);

        // Back-to-back pushes without grant
        cyc(1, 2'b10, 0, 0, 2'd0, 64'd0, 0, 0);
        cyc(1, 2'b11, 0, 1, 2'd0, 64'hAAAA_BBBB_CCCC_DDDD, 0, 0);
        cyc(0, 2'b00, 0, 1, 2'd1, 64'h0102_0304_0506_0708, 0, 0);
        chk("b2b_full",  64'(amo_wb_full), 64'd1);
        chk("b2b_ovf",   64'(amo_wb_ovf), 64'd0);
        chk("b2b_head",  amo_wb_stb_data, 64'hCCCC_DDDD_CCCC_DDDD);
        chk("b2b_bytes", 64'(amo_wb_stb_bytes_vld), 64'h0F);
        cyc(0, 2'b00, 0, 0, 2'd0, 64'd0, 1, 0);
        chk("b2b_second_id",   64'(amo_wb_stb_id), 64'd1);
        chk("b2b_second_data", amo_wb_stb_data, 64'h0102_0304_0506_0708);

        // Push in FULL: dropped without grant, accepted with grant
        cyc(0, 2'b00, 0, 1, 2'd3, 64'h3333_3333_3333_3333, 0, 0);
        cyc(0, 2'b00, 0, 1, 2'd2, 64'h4444_4444_4444_4444, 0, 0);
        chk("drop_ovf",  64'(amo_wb_ovf), 64'd1);
        chk("drop_head", 64'(amo_wb_stb_id), 64'd1);
        cyc(0, 2'b00, 0, 1, 2'd0, 64'h5555_5555_5555_5555, 1, 0);
        chk("fullpush_full", 64'(amo_wb_full), 64'd1);
        chk("fullpush_head", 64'(amo_wb_stb_id), 64'd3);
        cyc(0, 2'b00, 0, 0, 2'd0, 64'd0, 1, 0);
        chk("fullpush_tail", amo_wb_stb_data, 64'h5555_5555_5555_5555);
        cyc(0, 2'b00, 0, 0, 2'd0, 64'd0, 1, 0);

        // Flush together with a push in ONE
        cyc(0, 2'b00, 0, 1, 2'd1, 64'h6666_6666_6666_6666, 0, 0);
        cyc(0, 2'b00, 0, 1, 2'd2, 64'h7777_7777_7777_7777, 0, 1);
        chk("flush_vld",  64'(amo_wb_stb_vld), 64'd0);
        chk("flush_busy", 64'(amo_wb_busy), 64'd0);
        chk("flush_full", 64'(amo_wb_full), 64'd0);
        chk("flush_ovf_kept", 64'(amo_wb_ovf), 64'd1);

        // Reset mid-operation with two entries pending
        cyc(0, 2'b00, 0, 1, 2'd1, 64'h8888_8888_8888_8888, 0, 0);
        cyc(0, 2'b00, 0, 1, 2'd2, 64'h9999_9999_9999_9999, 0, 0);
        chk("pre_rst_full", 64'(amo_wb_full), 64'd1);
        cpurst_b = 1'b0;
        #1;
        chk_all_zero("mid_reset");
        model_reset();
        @(negedge amo_clk);
        cpurst_b = 1'b1;
        cyc(1, 2'b11, 0, 0, 2'd0, 64'd0, 0, 0);
        cyc(0, 2'b00, 0, 1, 2'd3, 64'hDEAD_BEEF_0000_0001, 0, 0);
        chk("after_rst_head", amo_wb_stb_data, 64'hDEAD_BEEF_0000_0001);
        chk("after_rst_rptr", 64'(dut.r_rptr), 64'd0);
        chk("after_rst_wptr", 64'(dut.r_wptr), 64'd1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 99) < 55), 2'($urandom_range(0, 3)),
                {32'($urandom), 32'($urandom)},
                1'($urandom_range(0, 99) < 40), 1'($urandom_range(0, 99) < 3));
            if (i == 1500) begin
                cpurst_b = 1'b0;
                #1;
                chk_all_zero("rand_reset");
                model_reset();
                @(negedge amo_clk);
                cpurst_b = 1'b1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
